// File: rtl/counter_sequencer_if.sv
// Command/status bundle between a host command source and counter_sequencer.
// The host drives the command side (master); the sequencer drives status (slave).
interface counter_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
);
    logic             start;
    logic             abort;
    logic             pause;
    logic             periodic;
    logic [WIDTH-1:0] tc;
    logic [REP_W-1:0] reps;
    logic [WIDTH-1:0] cnt;
    logic             cout;
    logic [REP_W-1:0] rep_cnt;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pause, periodic, tc, reps,
        input  cnt, cout, rep_cnt, busy, done
    );

    modport slave (
        input  start, abort, pause, periodic, tc, reps,
        output cnt, cout, rep_cnt, busy, done
    );
endinterface

// File: rtl/counter_sequencer.sv
// Sequencing controller around a WIDTH-bit up-counter. A start command latches
// the terminal count, extra-pass count and periodic flag into shadow registers,
// then the counter runs 0..tc_q repeatedly until the pass budget is spent (or
// forever in periodic mode). abort returns to IDLE, pause freezes the count.
module counter_sequencer #(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
) (
    input logic                clk,
    input logic                rst,
    counter_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] tc_q;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] reps_q;
    logic             per_q;
    logic             cout;
    logic             busy;
    logic             done;

    // A wrap on this edge ends the run only when the pass budget is used up
    // and the run is not periodic.
    function automatic logic last_pass(input logic             per,
                                       input logic [REP_W-1:0] rep_now,
                                       input logic [REP_W-1:0] rep_lim);
        return !per && (rep_now == rep_lim);
    endfunction

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            tc_q    <= '0;
            rep_cnt <= '0;
            reps_q  <= '0;
            per_q   <= 1'b0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cout <= 1'b0;
                    done <= 1'b0;
                    if (bus.start) begin
                        tc_q    <= bus.tc;
                        reps_q  <= bus.reps;
                        per_q   <= bus.periodic;
                        cnt     <= '0;
                        rep_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end

                RUN: begin
                    if (bus.abort) begin
                        cnt     <= '0;
                        rep_cnt <= '0;
                        cout    <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (bus.pause) begin
                        cout  <= 1'b0;
                        state <= PAUSE;
                    end else if (cnt != tc_q) begin
                        cnt  <= cnt + 1'b1;
                        cout <= 1'b0;
                    end else begin
                        cnt  <= '0;
                        cout <= 1'b1;
                        if (last_pass(per_q, rep_cnt, reps_q)) begin
                            // rep_cnt keeps its final value through DONE.
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            // Periodic runs let this roll over silently.
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                end

                PAUSE: begin
                    cout <= 1'b0;
                    if (bus.abort) begin
                        cnt     <= '0;
                        rep_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (!bus.pause) begin
                        // Resume edge only changes state; counting picks up next edge.
                        state <= RUN;
                    end
                end

                DONE: begin
                    // DONE lasts exactly one cycle and ignores start/abort.
                    cout  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    cnt     <= '0;
                    rep_cnt <= '0;
                    cout    <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.cnt     = cnt;
    assign bus.cout    = cout;
    assign bus.rep_cnt = rep_cnt;
    assign bus.busy    = busy;
    assign bus.done    = done;

    // The count never runs past the latched terminal value during a run.
    a_cnt_in_range: assert property (@(posedge clk) disable iff (rst)
        busy |-> (cnt <= tc_q));

    // Completion is a single-cycle pulse.
    a_done_single: assert property (@(posedge clk) disable iff (rst)
        done |=> !done);

    // A frozen or idle counter keeps its value unless a command moves it.
    a_cnt_stable: assert property (@(posedge clk) disable iff (rst)
        (((state == PAUSE) && !bus.abort) || ((state == IDLE) && !bus.start))
        |=> $stable(cnt));

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: a vector table of command inputs and
// expected registered outputs, plus hand-written asynchronous-reset sequences.
module tb_counter_sequencer;

    logic clk;
    logic rst;

    counter_sequencer_if #(.WIDTH(4), .REP_W(4)) bus ();

    counter_sequencer #(.WIDTH(4), .REP_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       abort;
        logic       pause;
        logic       periodic;
        logic [3:0] tc;
        logic [3:0] reps;
        logic [3:0] cnt;
        logic       cout;
        logic [3:0] rep;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_bad;

    function automatic void add(input logic s, input logic a, input logic p,
                                input logic per, input logic [3:0] t,
                                input logic [3:0] r, input logic [3:0] c,
                                input logic co, input logic [3:0] rc,
                                input logic b, input logic d);
        vec_t v;
        v.start = s;  v.abort = a; v.pause = p; v.periodic = per;
        v.tc    = t;  v.reps  = r;
        v.cnt   = c;  v.cout  = co; v.rep = rc; v.busy = b; v.done = d;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [3:0] c, input logic co,
                         input logic [3:0] rc, input logic b, input logic d);
        n_cmp++;
        if ({bus.cnt, bus.cout, bus.rep_cnt, bus.busy, bus.done} !== {c, co, rc, b, d}) begin
            n_bad++;
            $display("FAIL %s: got cnt=%0d cout=%b rep_cnt=%0d busy=%b done=%b, want cnt=%0d cout=%b rep_cnt=%0d busy=%b done=%b",
                     name, bus.cnt, bus.cout, bus.rep_cnt, bus.busy, bus.done, c, co, rc, b, d);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic a, input logic p, input logic per,
                         input logic [3:0] t, input logic [3:0] r);
        bus.start = s; bus.abort = a; bus.pause = p; bus.periodic = per;
        bus.tc = t; bus.reps = r;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // tc=3, reps=1: two passes, done 8 edges after start.
        add(1,0,0,0,3,1, 0,0,0,1,0);
        for (int i = 1; i <= 7; i++)
            add(0,0,0,0,3,1, 4'(i % 4), (i % 4) == 0, 4'(i / 4), 1, 0);
        add(0,0,0,0,3,1, 0,1,1,0,1);
        add(0,0,0,0,3,1, 0,0,1,0,0);
        add(0,1,0,0,3,1, 0,0,1,0,0);           // abort in IDLE ignored
        // tc=15, reps=0: full range, one pass.
        add(1,0,0,0,15,0, 0,0,0,1,0);
        for (int i = 1; i <= 15; i++)
            add(0,0,0,0,15,0, 4'(i), 0, 0, 1, 0);
        add(0,0,0,0,15,0, 0,1,0,0,1);
        add(0,0,0,0,15,0, 0,0,0,0,0);
        add(0,0,0,0,15,0, 0,0,0,0,0);
        // tc=0, reps=2: wrap every cycle, three passes.
        add(1,0,0,0,0,2, 0,0,0,1,0);
        add(0,0,0,0,0,2, 0,1,1,1,0);
        add(0,0,0,0,0,2, 0,1,2,1,0);
        add(0,0,0,0,0,2, 0,1,2,0,1);
        add(0,0,0,0,0,2, 0,0,2,0,0);
        // second run, abort+pause together -> IDLE, not PAUSE
        add(1,0,0,0,0,2, 0,0,0,1,0);
        add(0,1,1,0,0,2, 0,0,0,0,0);
        add(0,0,1,0,0,2, 0,0,0,0,0);
        // periodic tc=2 for 20 edges, then abort.
        add(1,0,0,1,2,0, 0,0,0,1,0);
        for (int i = 1; i <= 20; i++)
            add(0,0,0,1,2,0, 4'(i % 3), (i % 3) == 0, 4'(i / 3), 1, 0);
        add(0,1,0,1,2,0, 0,0,0,0,0);
        // periodic tc=0, rep_cnt rolls over 15->0; periodic input dropped mid-run.
        add(1,0,0,1,0,0, 0,0,0,1,0);
        for (int i = 1; i <= 18; i++)
            add(0,0,0,0,0,0, 0, 1, 4'(i % 16), 1, 0);
        add(0,1,0,0,0,0, 0,0,0,0,0);
        // tc=5 with a 4-cycle pause at cnt=2.
        add(1,0,0,0,5,0, 0,0,0,1,0);
        add(0,0,0,0,5,0, 1,0,0,1,0);
        add(0,0,0,0,5,0, 2,0,0,1,0);
        for (int i = 0; i < 4; i++)
            add(0,0,1,0,5,0, 2,0,0,1,0);
        add(0,0,0,0,5,0, 2,0,0,1,0);           // resume edge holds
        add(0,0,0,0,5,0, 3,0,0,1,0);
        add(0,0,0,0,5,0, 4,0,0,1,0);
        add(0,0,0,0,5,0, 5,0,0,1,0);
        add(0,0,0,0,5,0, 0,1,0,0,1);
        add(0,0,0,0,5,0, 0,0,0,0,0);
        // tc=7: tc/reps change and start pulse at cnt=4 have no effect.
        add(1,0,0,0,7,0, 0,0,0,1,0);
        for (int i = 1; i <= 4; i++)
            add(0,0,0,0,7,0, 4'(i), 0, 0, 1, 0);
        add(1,0,0,0,1,3, 5,0,0,1,0);
        add(0,0,0,0,1,3, 6,0,0,1,0);
        add(0,0,0,0,1,3, 7,0,0,1,0);
        add(0,0,0,0,1,3, 0,1,0,0,1);
        add(1,0,0,0,1,3, 0,0,0,0,0);           // start in DONE ignored

        // Reset state.
        drive(0,0,0,0,0,0);
        rst = 1'b1;
        step();
        step();
        check("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        foreach (vecs[k]) begin
            drive(vecs[k].start, vecs[k].abort, vecs[k].pause, vecs[k].periodic,
                  vecs[k].tc, vecs[k].reps);
            step();
            check($sformatf("vec%0d", k), vecs[k].cnt, vecs[k].cout, vecs[k].rep,
                  vecs[k].busy, vecs[k].done);
        end

        // Asynchronous reset mid-run at cnt=5.
        drive(1,0,0,0,7,0);
        step();
        drive(0,0,0,0,7,0);
        for (int i = 0; i < 5; i++) step();
        check("pre_rst_cnt5", 5, 0, 0, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", 0, 0, 0, 0, 0);
        step();
        check("rst_held", 0, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        step();
        check("after_rst_idle", 0, 0, 0, 0, 0);
        step();
        check("after_rst_no_done", 0, 0, 0, 0, 0);

        // Shadow registers cleared by reset: a fresh start uses the new tc only.
        drive(1,0,0,0,1,0);
        step();
        drive(0,0,0,0,1,0);
        step();
        check("post_rst_cnt1", 1, 0, 0, 1, 0);
        step();
        check("post_rst_done", 0, 1, 0, 0, 1);
        step();
        check("post_rst_idle", 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Sequencing controller wrapped around a WIDTH-bit up-counter, the same resource as the team's 4-bit counter.
- Accepts a start/abort/pause command interface and runs the counter from 0 to a programmed terminal count.
- Repeats that pass a programmed number of times, or forever in periodic mode, and reports busy/done/cout.
- Sits between a host command source and any logic consuming cnt/cout as a timebase.

Parameters:
WIDTH, 4, counter width in bits
REP_W, 4, repeat-count width in bits

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous reset, active-high
start  input  1  level-sampled command; accepted only in IDLE
abort  input  1  terminate the run; acts in RUN and PAUSE
pause  input  1  freeze counting while high; acts in RUN
periodic  input  1  sampled with start; 1 = repeat until abort
tc  input  WIDTH  terminal count, sampled with start
reps  input  REP_W  extra passes, sampled with start; total passes = reps+1
cnt  output  WIDTH  current count, registered
cout  output  1  one-cycle wrap flag, registered
rep_cnt  output  REP_W  completed-pass count, registered
busy  output  1  high in RUN and PAUSE
done  output  1  one-cycle completion pulse, high in DONE

Behaviour:
- Reset: one clock, clk. rst is asynchronous and active-high.
  - While rst=1: state=IDLE; cnt=0, cout=0, rep_cnt=0, busy=0, done=0; shadow tc_q/reps_q/per_q=0.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered and update on the clk rising edge.
- IDLE:
  - start=1 latches tc→tc_q, reps→reps_q, periodic→per_q; clears cnt and rep_cnt; goes to RUN.
  - busy=1 from the cycle after start is sampled.
  - Inputs are ignored otherwise; cnt holds its last value.
- RUN, per edge, priority abort > pause > count:
  - abort=1 → IDLE; cnt=0, rep_cnt=0, cout=0, done stays 0.
  - pause=1 → PAUSE; cnt and rep_cnt hold; cout=0.
  - cnt≠tc_q → cnt=cnt+1, cout=0.
  - cnt==tc_q (wrap) → cnt=0, cout=1.
    - If per_q=0 and rep_cnt==reps_q → DONE; rep_cnt holds its final value.
    - Otherwise rep_cnt=rep_cnt+1 (modulo 2^REP_W) and stay in RUN.
- PAUSE:
  - abort=1 → IDLE, cleared as above.
  - pause=0 → RUN; counting resumes on the following edge.
  - Otherwise everything holds.
  - cout=0 in PAUSE.
- DONE:
  - done=1, busy=0; cnt=0; cout=1 only in the first DONE cycle (the wrap edge).
  - Unconditionally → IDLE on the next edge. start in DONE is ignored.
- Latency (start sampled at edge k):
  - After edge k: cnt=0, busy=1.
  - After edge k+1: cnt=1.
  - Non-periodic run with no pause: RUN lasts (tc+1)*(reps+1) cycles; done is asserted after edge k+(tc+1)*(reps+1).
- Boundary conditions:
  - tc=0 → cnt stays 0 and every RUN cycle is a wrap (cout=1 each cycle).
  - tc=2^WIDTH-1 → full-range count; cnt arithmetic wraps naturally.
  - reps=0 → one pass only.
  - periodic rep_cnt wraps 2^REP_W-1→0 silently.
  - tc/reps/periodic changing mid-run has no effect, because the shadow registers are used.
  - abort and pause together → abort wins.
  - abort in IDLE or DONE → ignored.
  - rst mid-run → immediate return to reset values, no done pulse.
- Assertions required in RTL:
  - cnt never exceeds tc_q while busy.
  - done is never high on two consecutive cycles.
  - cnt is stable whenever state is PAUSE or IDLE.

Test Plan:
- Reset then tc=3, reps=1, periodic=0, start for 1 cycle → cnt 0,1,2,3,0,1,2,3,0; cout=1 on both wraps; rep_cnt 0→1; done=1 for one cycle 8 cycles after start; busy falls with done.
- tc=15, reps=0 → cnt counts 0..15 then 0 with cout=1 and done=1 on the same cycle; cnt stays 0 in IDLE.
- tc=2, periodic=1, run 20 cycles, then abort → cout every 3rd cycle; done never high; after abort, cnt=0, rep_cnt=0, busy=0.
- tc=5, pause=1 for 4 cycles while cnt=2 → cnt holds 2 and cout=0 throughout; counting resumes 3,4,5,0; total busy time extended by exactly 4 cycles plus 1 resume cycle.
- Mid-run edge cases, tc=7:
  - Change tc to 1 and pulse start at cnt=4 → no effect; wrap occurs at 7.
  - Assert rst at cnt=5 → all outputs 0 asynchronously, before the next clk edge.
- tc=0, reps=2 → cout=1 for 3 consecutive cycles; done after 3 cycles; abort+pause together in a second run → IDLE, not PAUSE.
